stream_upsizer: RTL and testbench

//  Width up-converter sitting directly downstream of an operator's input async FIFO shell, in the consumer clock domain.

---
 rtl/stream_pkg.sv | 22 ++
 rtl/stream_stat_counter.sv | 20 ++
 rtl/stream_upsizer.sv | 122 ++++++++++++
 tb/tb_stream_upsizer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream_upsizer block: FSM encoding and a
// constant-evaluable clog2 used to size the lane index.
package stream_pkg;

    localparam logic FILL = 1'b0;
    localparam logic HOLD = 1'b1;

    typedef enum logic {
        ST_FILL = FILL,
        ST_HOLD = HOLD
    } fsm_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_stat_counter.sv
// 32-bit statistics counter: synchronous clear (priority), count enable,
// and a freeze input that holds the value while the operator is idle.
module stream_stat_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        freeze,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && !freeze) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow val/ready words into one wide word; last_in flushes a
// partial word marked by keep_out. Statistics built only with STREAM_UPSIZER_STATS_EN.
module stream_upsizer
    import stream_pkg::*;
#(
    parameter  int IN_WIDTH  = 32,
    parameter  int RATIO     = 4,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO,
    localparam int IDX_W     = clog2(RATIO)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 val_in,
    input  logic                 last_in,
    output logic                 ready_upward,
    output logic [OUT_WIDTH-1:0] dout,
    output logic [RATIO-1:0]     keep_out,
    output logic                 last_out,
    output logic                 val_out,
    input  logic                 ready_downward,
    input  logic                 reset_ap_start,
    input  logic                 state,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          in_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    fsm_e             st, st_nxt;
    logic [IDX_W-1:0] idx;
    logic             in_acc;
    logic             out_acc;
    logic             word_done;

    // Handshake depends only on FSM state and the consumer, never on val_in.
    assign val_out      = (st == ST_HOLD);
    assign ready_upward = val_out ? ready_downward : 1'b1;
    assign in_acc       = val_in && ready_upward;
    assign out_acc      = val_out && ready_downward;
    assign word_done    = (idx == LAST_IDX) || last_in;

    always_ff @(posedge clk) begin
        if (reset) st <= ST_FILL;
        else       st <= st_nxt;
    end

    // NOTE: default assigned first so no path through the block leaves st_nxt unassigned (no latch).
    always_comb begin
        st_nxt = st;
        unique case (st)
            ST_FILL: if (in_acc && word_done) st_nxt = ST_HOLD;
            ST_HOLD: if (out_acc && !(in_acc && last_in)) st_nxt = ST_FILL;
            default: st_nxt = ST_FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout     <= '0;
            keep_out <= '0;
            last_out <= 1'b0;
            idx      <= '0;
        end else begin
            unique case (st)
                ST_FILL: begin
                    if (in_acc) begin
                        dout[idx*IN_WIDTH +: IN_WIDTH] <= din;
                        keep_out[idx]                  <= 1'b1;
                        if (word_done) begin
                            last_out <= last_in;
                            idx      <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_acc && in_acc) begin
                        // Drain and refill in one cycle: new word lands in lane 0 of a cleared register.
                        dout     <= OUT_WIDTH'(din);
                        keep_out <= RATIO'(1);
                        last_out <= last_in;
                        idx      <= last_in ? '0 : IDX_W'(1);
                    end else if (out_acc) begin
                        dout     <= '0;
                        keep_out <= '0;
                        last_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef STREAM_UPSIZER_STATS_EN
    stream_stat_counter u_stall_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (reset_ap_start),
        .en     (val_out && !ready_downward),
        .freeze (state),
        .count  (stall_cnt)
    );

    stream_stat_counter u_in_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (reset_ap_start),
        .en     (in_acc),
        .freeze (state),
        .count  (in_cnt)
    );
`else
    logic unused_stats;
    assign unused_stats = &{1'b0, reset_ap_start, state};
    assign stall_cnt    = '0;
    assign in_cnt       = '0;
`endif

endmodule

// File: tb/tb_stream_upsizer.sv
// Self-checking bench for stream_upsizer (RATIO=4): directed scenarios plus
// randomized traffic, all checked against a frame-level packing model.
module tb_stream_upsizer;

    localparam int IN_W  = 32;
    localparam int RATIO = 4;
    localparam int OUT_W = IN_W * RATIO;
`ifdef STREAM_UPSIZER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [RATIO-1:0] keep;
        logic             last;
    } word_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [IN_W-1:0]  din;
    logic             val_in, last_in, ready_upward;
    logic [OUT_W-1:0] dout;
    logic [RATIO-1:0] keep_out;
    logic             last_out, val_out, ready_downward;
    logic             reset_ap_start, state;
    logic [31:0]      stall_cnt, in_cnt;

    int checks   = 0;
    int failures = 0;

    word_t           exp_q[$];
    logic [IN_W-1:0] part[$];
    logic [31:0]     m_stall = '0;
    logic [31:0]     m_in    = '0;

    always #5 clk = ~clk;

    stream_upsizer #(.IN_WIDTH(IN_W), .RATIO(RATIO)) dut (
        .clk            (clk),
        .reset          (reset),
        .din            (din),
        .val_in         (val_in),
        .last_in        (last_in),
        .ready_upward   (ready_upward),
        .dout           (dout),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .val_out        (val_out),
        .ready_downward (ready_downward),
        .reset_ap_start (reset_ap_start),
        .state          (state),
        .stall_cnt      (stall_cnt),
        .in_cnt         (in_cnt)
    );

    task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then compare the DUT
    // against the model and advance the model for the coming rising edge.
    task automatic step(input logic v, input logic [IN_W-1:0] d, input logic l, input logic rd,
                        input logic st, input logic rap, input logic rst);
        bit    hold, in_acc;
        word_t w;
        @(negedge clk);
        val_in = v; din = d; last_in = l; ready_downward = rd;
        state = st; reset_ap_start = rap; reset = rst;
        #1;
        hold = (exp_q.size() != 0);
        check("val_out", OUT_W'(val_out), OUT_W'(hold));
        check("ready_upward", OUT_W'(ready_upward), OUT_W'(hold ? rd : 1'b1));
        if (hold) begin
            check("dout", dout, exp_q[0].data);
            check("keep_out", OUT_W'(keep_out), OUT_W'(exp_q[0].keep));
            check("last_out", OUT_W'(last_out), OUT_W'(exp_q[0].last));
        end
        check("stall_cnt", OUT_W'(stall_cnt), OUT_W'(STATS ? m_stall : 32'd0));
        check("in_cnt", OUT_W'(in_cnt), OUT_W'(STATS ? m_in : 32'd0));
        if (rst) begin
            exp_q.delete(); part.delete();
            m_stall = '0; m_in = '0;
            return;
        end
        in_acc = v && (hold ? rd : 1'b1);
        if (rap) begin
            m_stall = '0; m_in = '0;
        end else begin
            if (hold && !rd && !st) m_stall = m_stall + 32'd1;
            if (in_acc && !st)      m_in    = m_in + 32'd1;
        end
        if (hold && rd) void'(exp_q.pop_front());
        if (in_acc) begin
            part.push_back(d);
            if (part.size() == RATIO || l) begin
                w.data = '0;
                for (int i = 0; i < part.size(); i++) w.data[i*IN_W +: IN_W] = part[i];
                w.keep = RATIO'((1 << part.size()) - 1);
                w.last = l;
                exp_q.push_back(w);
                part.delete();
            end
        end
    endtask

    task automatic idle(input logic rd);
        step(1'b0, '0, 1'b0, rd, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; val_in = 1'b0; din = '0; last_in = 1'b0;
        ready_downward = 1'b0; state = 1'b0; reset_ap_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_val_out", OUT_W'(val_out), '0);
        check("rst_dout", dout, '0);
        check("rst_keep", OUT_W'(keep_out), '0);
        check("rst_last", OUT_W'(last_out), '0);
        check("rst_stall", OUT_W'(stall_cnt), '0);
        check("rst_in_cnt", OUT_W'(in_cnt), '0);

        // Back-to-back full words with the consumer always ready.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, IN_W'(i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 5) check("b2b_word0", dout, 128'h00000004_00000003_00000002_00000001);
        end
        idle(1'b1);
        check("b2b_word1", dout, 128'h00000008_00000007_00000006_00000005);
        check("b2b_keep", OUT_W'(keep_out), OUT_W'(4'hF));

        // Early last_in flushes a three-lane partial word.
        step(1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("part_dout", dout, 128'h00000000_0000000C_0000000B_0000000A);
        check("part_keep", OUT_W'(keep_out), OUT_W'(4'h7));
        check("part_last", OUT_W'(last_out), OUT_W'(1'b1));
        idle(1'b1);

        // Consumer stalls for 10 cycles on a full word.
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, IN_W'(32'h20 + i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stall_dout", dout, 128'h00000023_00000022_00000021_00000020);
        check("stall_ready", OUT_W'(ready_upward), '0);
        idle(1'b1);
        check("stall_cnt10", OUT_W'(stall_cnt), OUT_W'(STATS ? 32'd10 : 32'd0));

        // Reset mid-fill discards the partial word.
        step(1'b1, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 5; i <= 8; i++) step(1'b1, IN_W'(i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("rstfill_dout", dout, 128'h00000008_00000007_00000006_00000005);
        check("rstfill_keep", OUT_W'(keep_out), OUT_W'(4'hF));
        idle(1'b1);

        // Single-word frame accepted while the held word drains.
        for (int i = 0; i < 4; i++) step(1'b1, IN_W'(32'h11 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        check("first_last_dout", dout, 128'h77);
        check("first_last_keep", OUT_W'(keep_out), OUT_W'(4'h1));
        check("first_last_last", OUT_W'(last_out), OUT_W'(1'b1));

        // Counters frozen in the idle/config phase, then cleared.
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, IN_W'(32'h40 + i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("frozen_in_cnt", OUT_W'(in_cnt), '0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        check("clr_in_cnt", OUT_W'(in_cnt), '0);
        check("clr_stall", OUT_W'(stall_cnt), '0);

        // Randomized traffic with occasional resets, clears and freezes.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
